// File: rtl/pulse_train_gen.sv
// pulse_train_gen: expands one start request into TOTAL_COUNT evenly spaced single-cycle pulses.
// Optional abort port and cancel logic are enabled by defining PULSE_TRAIN_ABORT_EN.
module pulse_train_gen #(
   parameter int TOTAL_COUNT = 3,
   parameter int PERIOD      = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
`ifdef PULSE_TRAIN_ABORT_EN
   input  logic abort,
`endif
   output logic pulse_out,
   output logic busy,
   output logic done
);
   localparam int CW = $clog2(TOTAL_COUNT + 1);
   localparam int PW = $clog2(PERIOD);
   localparam logic [CW-1:0] CNT_LAST = CW'(TOTAL_COUNT);
   localparam logic [PW-1:0] PH_LAST  = PW'(PERIOD - 1);

   generate
      if (TOTAL_COUNT < 1 || PERIOD < 2) begin : g_bad_params
         $error("pulse_train_gen: TOTAL_COUNT must be >= 1 and PERIOD >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
   state_t state, state_n;
   logic [CW-1:0] pulse_cnt, pulse_cnt_n;
   logic [PW-1:0] phase_cnt, phase_cnt_n;
   logic kill;

`ifdef PULSE_TRAIN_ABORT_EN
   assign kill = abort && state != IDLE;
`else
   assign kill = 1'b0;
`endif

   // phase_cnt is 0 in PULSE and advances through GAP, so PULSE-to-PULSE spacing is PERIOD
   always_comb begin
      state_n     = state;
      pulse_cnt_n = pulse_cnt;
      phase_cnt_n = phase_cnt;
      if (kill)
         state_n = IDLE;
      else
         case (state)
            IDLE: if (start) begin
               state_n     = PULSE;
               pulse_cnt_n = '0;
               phase_cnt_n = '0;
            end
            PULSE: begin
               state_n     = GAP;
               pulse_cnt_n = pulse_cnt + 1'b1;
               phase_cnt_n = phase_cnt + 1'b1;
            end
            GAP: if (phase_cnt == PH_LAST) begin
               state_n     = (pulse_cnt == CNT_LAST) ? IDLE : PULSE;
               phase_cnt_n = '0;
            end else
               phase_cnt_n = phase_cnt + 1'b1;
            default: state_n = IDLE;
         endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pulse_cnt <= '0;
         phase_cnt <= '0;
         pulse_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         pulse_cnt <= pulse_cnt_n;
         phase_cnt <= phase_cnt_n;
         pulse_out <= state_n == PULSE;
         busy      <= state_n != IDLE;
         done      <= state_n == GAP && phase_cnt_n == PH_LAST && pulse_cnt_n == CNT_LAST;
      end
   end
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed checks of burst timing, continuous start, reset and optional abort.
module tb_pulse_train_gen;
   logic clk = 1'b0;
   logic rst_n, start, start2, abort;
   logic pulse_out, busy, done, pulse2, busy2, done2;
   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pulse_train_gen #(.TOTAL_COUNT(3), .PERIOD(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef PULSE_TRAIN_ABORT_EN
      .abort(abort),
`endif
      .pulse_out(pulse_out), .busy(busy), .done(done));

   pulse_train_gen #(.TOTAL_COUNT(1), .PERIOD(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef PULSE_TRAIN_ABORT_EN
      .abort(abort),
`endif
      .pulse_out(pulse2), .busy(busy2), .done(done2));

   // expected {pulse, busy, done} c cycles after the edge that accepted start
   function automatic logic [2:0] burst(int c, int tc, int p);
      logic b;
      b = c >= 1 && c <= tc * p;
      return {b && ((c - 1) % p == 0), b, c == tc * p};
   endfunction

   task automatic chk(string tag, int cyc, logic [2:0] obs, logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cycle %0d observed {pulse,busy,done}=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0;
      step();
      chk("reset", 0, {pulse_out, busy, done}, 3'b000);
      chk("reset2", 0, {pulse2, busy2, done2}, 3'b000);
      rst_n = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk("idle", c, {pulse_out, busy, done}, 3'b000);
      end
      // cycle 0: start both; dut keeps start high for back-to-back bursts
      start = 1'b1; start2 = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (c == 1) start2 = 1'b0;
         chk("continuous", c, {pulse_out, busy, done}, burst(((c - 1) % 13) + 1, 3, 4));
         chk("edge_params", c, {pulse2, busy2, done2}, burst(c, 1, 2));
      end
      start = 1'b0;
      step();
      chk("after_bursts", 26, {pulse_out, busy, done}, 3'b000);
      for (int c = 0; c < 3; c++) step();
      // reset in the middle of a burst
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         start = 1'b0;
         chk("pre_reset", c, {pulse_out, busy, done}, burst(c, 3, 4));
      end
      rst_n = 1'b0;
      #1;
      chk("async_reset", 6, {pulse_out, busy, done}, 3'b000);
      #2;
      rst_n = 1'b1;
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         step();
         start = 1'b0;
         chk("post_reset", c, {pulse_out, busy, done}, burst(c, 3, 4));
      end
`ifdef PULSE_TRAIN_ABORT_EN
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         start = 1'b0;
         chk("pre_abort", c, {pulse_out, busy, done}, burst(c, 3, 4));
      end
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abort", 7, {pulse_out, busy, done}, 3'b000);
      step();
      chk("no_restart", 8, {pulse_out, busy, done}, 3'b000);
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abort_idle_start", 9, {pulse_out, busy, done}, 3'b110);
      for (int c = 2; c <= 13; c++) begin
         step();
         chk("abort_idle_burst", c, {pulse_out, busy, done}, burst(c, 3, 4));
      end
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
